// File: rtl/cache_data_array_mw_if.sv
// Bus bundle for cache_data_array_mw: CPU read/write port plus the memory refill channel.
// master drives requests (controller / refill path); slave is the data array.
interface cache_data_array_mw_if #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int WAYS     = 2,
    parameter int WORD_W   = 32
);
    localparam int S_MASK = 2 ** S_OFFSET;
    localparam int S_LINE = 8 * S_MASK;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [WAY_W-1:0]   rway;
    logic [S_INDEX-1:0] rindex;
    logic [S_LINE-1:0]  dataout;
    logic [S_MASK-1:0]  write_en;
    logic [WAY_W-1:0]   wway;
    logic [S_INDEX-1:0] windex;
    logic [S_LINE-1:0]  datain;
    logic               fill_start;
    logic [WAY_W-1:0]   fill_way;
    logic [S_INDEX-1:0] fill_index;
    logic               fill_valid;
    logic [WORD_W-1:0]  fill_data;
    logic               fill_ready;
    logic               fill_abort;
    logic               fill_busy;
    logic               fill_done;

    modport master (
        output rway, rindex, write_en, wway, windex, datain,
        output fill_start, fill_way, fill_index, fill_valid, fill_data, fill_abort,
        input  dataout, fill_ready, fill_busy, fill_done
    );

    modport slave (
        input  rway, rindex, write_en, wway, windex, datain,
        input  fill_start, fill_way, fill_index, fill_valid, fill_data, fill_abort,
        output dataout, fill_ready, fill_busy, fill_done
    );
endinterface

// File: rtl/cache_data_array_mw.sv
// N-way byte-masked L1 data store with forwarded combinational read and an
// atomic line-fill engine (word-serial buffer, single-cycle commit).
module cache_data_array_mw #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int WAYS     = 2,
    parameter int WORD_W   = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    cache_data_array_mw_if.slave bus
);
    localparam int S_MASK   = 2 ** S_OFFSET;
    localparam int S_LINE   = 8 * S_MASK;
    localparam int NUM_SETS = 2 ** S_INDEX;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int N_WORDS  = S_LINE / WORD_W;
    localparam int CNT_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [S_LINE-1:0]  r_buf;
    logic [WAY_W-1:0]   r_fway;
    logic [S_INDEX-1:0] r_findex;
    logic               r_done;
    logic [S_LINE-1:0]  r_mem [WAYS][NUM_SETS];
    logic [S_LINE-1:0]  w_dout;
    logic               w_last;
    logic               w_accept;
    logic               w_fwd_hit;

    assign w_last    = (r_cnt == CNT_W'(N_WORDS - 1));
    assign w_accept  = (r_state == FILL) && bus.fill_valid && !bus.fill_abort;
    assign w_fwd_hit = (bus.rway == bus.wway) && (bus.rindex == bus.windex);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.fill_start) w_next = FILL;
            FILL: begin
                if (bus.fill_abort)          w_next = IDLE;
                else if (w_accept && w_last) w_next = COMMIT;
            end
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_buf    <= '0;
            r_fway   <= '0;
            r_findex <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == COMMIT);
            if (r_state == IDLE && bus.fill_start) begin
                r_cnt    <= '0;
                r_fway   <= bus.fill_way;
                r_findex <= bus.fill_index;
            end else if (w_accept) begin
                for (int unsigned k = 0; k < N_WORDS; k++)
                    if (CNT_W'(k) == r_cnt) r_buf[k*WORD_W +: WORD_W] <= bus.fill_data;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Commit first, CPU bytes after: on a same-line collision the later NBA wins per byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned w = 0; w < WAYS; w++)
                for (int unsigned s = 0; s < NUM_SETS; s++)
                    r_mem[w][s] <= '0;
        end else begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                for (int unsigned s = 0; s < NUM_SETS; s++) begin
                    if (r_state == COMMIT && WAY_W'(w) == r_fway && S_INDEX'(s) == r_findex)
                        r_mem[w][s] <= r_buf;
                    if (WAY_W'(w) == bus.wway && S_INDEX'(s) == bus.windex)
                        for (int unsigned b = 0; b < S_MASK; b++)
                            if (bus.write_en[b]) r_mem[w][s][8*b +: 8] <= bus.datain[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_dout = r_mem[bus.rway][bus.rindex];
        for (int unsigned b = 0; b < S_MASK; b++)
            if (bus.write_en[b] && w_fwd_hit) w_dout[8*b +: 8] = bus.datain[8*b +: 8];
    end

    assign bus.dataout    = w_dout;
    assign bus.fill_ready = (r_state == FILL);
    assign bus.fill_busy  = (r_state != IDLE);
    assign bus.fill_done  = r_done;
endmodule
